// File: rtl/alu_operand_stage.sv
`timescale 1ns/1ps
// Operand-fetch stage feeding the 16-bit ALU: decodes, reads the 16x16 register file with writeback bypass.
// Optional macro IMM_OPERAND_EN selects a sign-extended imm13 as operand2 when in_instr[13] is set.
module alu_operand_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int OPC_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [3:0]        out_rd,
  output logic              out_divz,
  output logic              out_illegal,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  localparam logic [OPC_W-1:0] OPC_DIV = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_NOT = OPC_W'(7);

  logic [DATA_W-1:0] rf_q [NREGS];

  logic              out_valid_q;
  logic [OPC_W-1:0]  opcode_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [3:0]        rd_q;
  logic              divz_q, illegal_q;

  logic [OPC_W-1:0]  opc;
  logic [3:0]        rd, rs1, rs2;
  logic [DATA_W-1:0] rs1_val, rs2_val;
  logic [DATA_W-1:0] op2_d;
  logic              divz_d, illegal_d;
  logic              accept;

  assign opc = in_instr[31:26];
  assign rd  = in_instr[25:22];
  assign rs1 = in_instr[21:18];
  assign rs2 = in_instr[17:14];

  // R0 is hardwired to zero, so it must also win over a same-cycle writeback to R0
  assign rs1_val = (rs1 == 4'd0) ? '0 :
                   (wb_en && wb_addr == rs1) ? wb_data : rf_q[rs1];
  assign rs2_val = (rs2 == 4'd0) ? '0 :
                   (wb_en && wb_addr == rs2) ? wb_data : rf_q[rs2];

  always_comb begin
    op2_d = rs2_val;
`ifdef IMM_OPERAND_EN
    if (in_instr[13])
      op2_d = {{(DATA_W-13){in_instr[12]}}, in_instr[12:0]};
`endif
    if (opc == OPC_NOT)
      op2_d = '0;
    divz_d    = (opc == OPC_DIV) && (op2_d == '0);
    illegal_d = (opc > OPC_NOT);
  end

`ifndef IMM_OPERAND_EN
  logic unused_imm;
  assign unused_imm = ^in_instr[13:0];
`endif

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        rf_q[i] <= '0;
    end else if (wb_en && wb_addr != 4'd0) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      divz_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      opcode_q    <= opc;
      op1_q       <= rs1_val;
      op2_q       <= op2_d;
      rd_q        <= rd;
      divz_q      <= divz_d;
      illegal_q   <= illegal_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opcode  = opcode_q;
  assign out_op1     = op1_q;
  assign out_op2     = op2_q;
  assign out_rd      = rd_q;
  assign out_divz    = divz_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
`timescale 1ns/1ps
// Self-checking bench for alu_operand_stage: directed literal checks plus a randomized run
// compared every cycle against a transaction-level model of the operand stage.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [5:0]  out_opcode;
  logic [15:0] out_op1, out_op2;
  logic [3:0]  out_rd;
  logic        out_divz, out_illegal;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;

  int errors = 0;
  int checks = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
    .out_divz(out_divz), .out_illegal(out_illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register array plus the single pending instruction
  logic [15:0] m_rf [16];
  logic        m_valid;
  logic [5:0]  m_opc;
  logic [15:0] m_op1, m_op2;
  logic [3:0]  m_rd;
  logic        m_divz, m_illegal;

  function automatic logic [15:0] reg_read(input logic [3:0] a);
    if (a == 0) return 16'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic logic [15:0] model_op2(input logic [31:0] ins);
    if (ins[31:26] == 6'd7) return 16'h0;
`ifdef IMM_OPERAND_EN
    if (ins[13]) return 16'($signed(ins[12:0]));
`endif
    return reg_read(ins[17:14]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_opc <= 0; m_op1 <= 0; m_op2 <= 0; m_rd <= 0;
      m_divz <= 0; m_illegal <= 0;
      for (int i = 0; i < 16; i++) m_rf[i] <= 16'h0;
    end else begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_valid   <= 1;
        m_opc     <= in_instr[31:26];
        m_op1     <= reg_read(in_instr[21:18]);
        m_op2     <= model_op2(in_instr);
        m_rd      <= in_instr[25:22];
        m_divz    <= (in_instr[31:26] == 6'd3) && (model_op2(in_instr) == 16'h0);
        m_illegal <= in_instr[31:26] > 6'd7;
      end else if (out_ready) begin
        m_valid <= 0;
      end
      if (wb_en && wb_addr != 0) m_rf[wb_addr] <= wb_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("in_ready", in_ready, !m_valid || out_ready);
      check("out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("opcode", out_opcode, m_opc);
        check("op1", out_op1, m_op1);
        check("op2", out_op2, m_op2);
        check("rd", out_rd, m_rd);
        check("divz", out_divz, m_divz);
        check("illegal", out_illegal, m_illegal);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2,
                                     input logic isel, input logic [12:0] imm);
    return {opc, rd, rs1, rs2, isel, imm};
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                      input logic we, input logic [3:0] wa, input logic [15:0] wd);
    in_valid = v; in_instr = ins; out_ready = ordy;
    wb_en = we; wb_addr = wa; wb_data = wd;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst op1", out_op1, 0);
    check("rst op2", out_op2, 0);
    check("rst rd/opc", {out_rd, out_opcode}, 0);
    check("rst flags", {out_divz, out_illegal}, 0);
    #1 rst_n = 1;

    // ADD rd=1 rs1=0 rs2=0
    step(1, mk(0, 1, 0, 0, 0, 0), 1, 0, 0, 0);
    @(negedge clk);
    check("t1 valid", out_valid, 1);
    check("t1 op1/op2", {out_op1, out_op2}, 0);
    check("t1 rd", out_rd, 1);

    step(0, 0, 1, 1, 3, 16'h1234);
    step(1, mk(1, 2, 3, 3, 0, 0), 1, 0, 0, 0);
    @(negedge clk);
    check("t2 regread", {out_op1, out_op2}, 32'h1234_1234);
    step(1, mk(0, 2, 5, 0, 0, 0), 1, 1, 5, 16'hBEEF);
    @(negedge clk);
    check("t2 bypass", out_op1, 16'hBEEF);

    // Stall: A held while B waits, with a writeback to A's source during the stall
    step(1, mk(0, 7, 3, 0, 0, 0), 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, mk(2, 9, 3, 0, 0, 0), 0, i == 1, 3, 16'h5555);
      @(negedge clk);
      check("t3 in_ready", in_ready, 0);
      check("t3 held op1", out_op1, 16'h1234);
      check("t3 held rd", out_rd, 7);
    end
    step(1, mk(2, 9, 3, 0, 0, 0), 1, 0, 0, 0);
    @(negedge clk);
    check("t3 no bubble", {out_valid, out_rd}, {1'b1, 4'd9});
    check("t3 new op1", out_op1, 16'h5555);

    step(1, mk(3, 4, 3, 0, 0, 0), 1, 0, 0, 0);
    @(negedge clk);
    check("t4 divz", out_divz, 1);
    step(1, mk(6'b001000, 4, 3, 0, 0, 0), 1, 0, 0, 0);
    @(negedge clk);
    check("t4 illegal", out_illegal, 1);
    step(1, mk(7, 1, 3, 3, 0, 0), 1, 0, 0, 0);
    @(negedge clk);
    check("t4 not op2", {out_op1, out_op2}, 32'h5555_0000);
    step(0, 0, 1, 1, 0, 16'hFFFF);
    step(1, mk(0, 1, 0, 0, 0, 0), 1, 1, 0, 16'hFFFF);
    @(negedge clk);
    check("t4 r0 zero", {out_op1, out_op2}, 0);

    step(1, mk(0, 1, 0, 3, 1, 13'h1FFF), 1, 0, 0, 0);
    @(negedge clk);
`ifdef IMM_OPERAND_EN
    check("t5 imm sext", out_op2, 16'hFFFF);
    step(1, mk(3, 1, 3, 3, 1, 13'h0), 1, 0, 0, 0);
    @(negedge clk);
    check("t5 imm divz", out_divz, 1);
`else
    check("t5 imm ignored", out_op2, 16'h5555);
`endif

    // Async reset while stalled
    step(1, mk(0, 2, 3, 3, 0, 0), 1, 0, 0, 0);
    step(1, mk(1, 3, 3, 3, 0, 0), 0, 0, 0, 0);
    #2 rst_n = 0;
    #1 check("t6 async drop", out_valid, 0);
    @(negedge clk);
    #1 rst_n = 1;
    step(1, mk(0, 1, 3, 5, 0, 0), 1, 0, 0, 0);
    @(negedge clk);
    check("t6 regs cleared", {out_valid, out_op1, out_op2}, {1'b1, 32'h0});

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      r = $urandom;
      step($urandom_range(0, 3) != 0, {6'($urandom_range(0, 9)), r[25:0]},
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), 16'($urandom));
    end
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
